// File: rtl/conv_window_gen.sv
// conv_window_gen: N x N sliding-window generator for a raster pixel stream,
// built from N-1 line buffers feeding an N x N column-shift register.
module conv_window_gen #(
    parameter int N     = 3,
    parameter int DW    = 12,
    parameter int IMG_W = 160,
    parameter int IMG_H = 120
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DW-1:0]     in_pix,
    output logic              in_ready,
    output logic              win_valid,
    output logic [N*N*DW-1:0] win_data,
    input  logic              win_ready,
    output logic              win_last,
    output logic              frame_done
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic              win_valid_q, win_valid_d;
    logic              win_last_q, win_last_d;
    logic              frame_done_q, frame_done_d;
    logic [N*N*DW-1:0] win_q, win_d;
    logic [DW-1:0]     lb_q [N-1][IMG_W];
    logic [DW-1:0]     col [N];
    logic              acc, x_end, y_end, qual;
    assign in_ready   = !win_valid_q || win_ready;
    assign acc        = in_valid && in_ready;
    assign x_end      = x_q == XW'(IMG_W - 1);
    assign y_end      = y_q == YW'(IMG_H - 1);
    assign qual       = acc && x_q >= XW'(N - 1) && y_q >= YW'(N - 1);
    assign win_valid  = win_valid_q;
    assign win_last   = win_last_q;
    assign frame_done = frame_done_q;
    assign win_data   = win_q;
    // Incoming column, top row first: oldest line buffer down to the live pixel.
    always_comb begin
        col[N-1] = in_pix;
        for (int r = 0; r < N - 1; r++) col[r] = lb_q[N-2-r][x_q];
    end
    always_comb begin
        x_d          = acc ? (x_end ? '0 : x_q + 1'b1) : x_q;
        y_d          = (acc && x_end) ? (y_end ? '0 : y_q + 1'b1) : y_q;
        win_valid_d  = qual || (win_valid_q && !win_ready);
        win_last_d   = qual ? (x_end && y_end) : win_last_q;
        frame_done_d = acc && x_end && y_end;
        win_d        = win_q;
        if (acc) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N - 1; c++) win_d[DW*(r*N+c) +: DW] = win_q[DW*(r*N+c+1) +: DW];
                win_d[DW*(r*N+N-1) +: DW] = col[r];
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q          <= '0;
            y_q          <= '0;
            win_valid_q  <= 1'b0;
            win_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            win_q        <= '0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            win_valid_q  <= win_valid_d;
            win_last_q   <= win_last_d;
            frame_done_q <= frame_done_d;
            win_q        <= win_d;
        end
    end
    // Non-blocking writes give read-before-write: each buffer passes its old line down.
    always_ff @(posedge clk) begin
        if (acc) begin
            lb_q[0][x_q] <= in_pix;
            for (int k = 1; k < N - 1; k++) lb_q[k][x_q] <= lb_q[k-1][x_q];
        end
    end
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: scenario table plus directed reset sequences, checked
// against a frame-array model that cuts each expected window out of the image.
module tb_conv_window_gen;
    localparam int N = 3, DW = 12, W = 8, H = 4, WD = N*N*DW;
    logic          clk = 1'b0, rst = 1'b1, in_valid = 1'b0, win_ready = 1'b1;
    logic [DW-1:0] in_pix = '0;
    logic          in_ready, win_valid, win_last, frame_done;
    logic [WD-1:0] win_data;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    conv_window_gen #(.N(N), .DW(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pix(in_pix), .in_ready(in_ready),
        .win_valid(win_valid), .win_data(win_data), .win_ready(win_ready),
        .win_last(win_last), .frame_done(frame_done)
    );

    typedef struct { logic [WD-1:0] d; logic l; } win_t;
    typedef struct { int vp; int rp; int fr; bit sq; int st; int exp_win; } vec_t;

    win_t          expq[$];
    logic [DW-1:0] img [H][W];
    int            mx = 0, my = 0, acc = 0, nwin = 0, acc_first = 0, stall_left = 0;
    bit            seen = 0, fd_exp = 0, prev_stall = 0, prev_last = 0;
    logic [WD-1:0] prev_data = '0, first_d = '0, last_d = '0;
    localparam logic [WD-1:0] F0 = {12'h022, 12'h021, 12'h020, 12'h012, 12'h011, 12'h010, 12'h002, 12'h001, 12'h000};
    localparam logic [WD-1:0] L0 = {12'h037, 12'h036, 12'h035, 12'h027, 12'h026, 12'h025, 12'h017, 12'h016, 12'h015};

    task automatic check(input string nm, input logic [WD-1:0] act, input logic [WD-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic win_t build(input int x, input int y);
        win_t w;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                w.d[DW*(r*N+c) +: DW] = img[y-N+1+r][x-N+1+c];
        w.l = (x == W - 1) && (y == H - 1);
        return w;
    endfunction

    task automatic cycle(input logic v, input logic r, input logic [DW-1:0] p);
        win_t w;
        @(negedge clk);
        check("frame_done", frame_done, fd_exp);
        check("win_valid", win_valid, expq.size() != 0);
        if (prev_stall) begin
            check("stall_data", win_data, prev_data);
            check("stall_last", win_last, prev_last);
        end
        if (win_valid && !seen) begin
            seen = 1;
            acc_first = acc;
        end
        if (stall_left > 0 && win_valid) begin
            r = 1'b0;
            stall_left--;
        end
        in_valid = v; win_ready = r; in_pix = p;
        #1;
        check("in_ready", in_ready, !win_valid || r);
        prev_stall = win_valid && !r;
        prev_data = win_data;
        prev_last = win_last;
        if (win_valid && r) begin
            if (expq.size() == 0) check("spurious_win", win_valid, 1'b0);
            else begin
                w = expq.pop_front();
                check("win_data", win_data, w.d);
                check("win_last", win_last, w.l);
                if (nwin == 0) first_d = win_data;
                last_d = win_data;
                nwin++;
            end
        end
        fd_exp = 0;
        if (v && in_ready) begin
            img[my][mx] = p;
            if (mx >= N - 1 && my >= N - 1) expq.push_back(build(mx, my));
            fd_exp = (mx == W - 1) && (my == H - 1);
            acc++;
            if (mx == W - 1) begin
                mx = 0;
                my = (my == H - 1) ? 0 : my + 1;
            end else mx++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0; win_ready = 1'b1; rst = 1'b1;
        #1;
        check("rst_valid", win_valid, 1'b0);
        check("rst_last", win_last, 1'b0);
        check("rst_done", frame_done, 1'b0);
        check("rst_data", win_data, '0);
        check("rst_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        mx = 0; my = 0; fd_exp = 0; prev_stall = 0;
        expq.delete();
    endtask

    task automatic run(input int vp, input int rp, input int fr, input bit sq, input int st);
        int b = 0;
        nwin = 0; acc = 0; seen = 0; acc_first = 0; stall_left = st;
        while (acc < fr*W*H && b < 3000) begin
            cycle($urandom_range(99) < vp, $urandom_range(99) < rp, sq ? DW'(my*16 + mx) : DW'($urandom));
            b++;
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, '0);
        check("accepts", acc, fr*W*H);
    endtask

    task automatic feed(input int n);
        int b = 0;
        acc = 0;
        while (acc < n && b < 200) begin
            cycle(1'b1, 1'b1, DW'(my*16 + mx));
            b++;
        end
        check("feed_accepts", acc, n);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{100, 100, 1, 1, 0, 12};
        vecs[1] = '{100, 100, 1, 1, 5, 12};
        vecs[2] = '{50, 100, 1, 1, 0, 12};
        vecs[3] = '{100, 100, 2, 1, 0, 24};
        vecs[4] = '{60, 60, 2, 0, 0, 24};
        for (int i = 0; i < 5; i++) begin
            do_reset();
            run(vecs[i].vp, vecs[i].rp, vecs[i].fr, vecs[i].sq, vecs[i].st);
            check("win_count", nwin, vecs[i].exp_win);
            if (vecs[i].sq) begin
                check("first_window", first_d, F0);
                check("last_window", last_d, L0);
            end
            if (vecs[i].vp == 100) check("first_latency", acc_first, 19);
        end
        do_reset();
        feed(13);
        do_reset();
        run(100, 100, 1, 1, 0);
        check("post_rst_count", nwin, 12);
        check("post_rst_first", first_d, F0);
        check("post_rst_latency", acc_first, 19);
        do_reset();
        feed(19);
        do_reset();
        run(100, 100, 1, 1, 0);
        check("rst_valid_count", nwin, 12);
        check("rst_valid_first", first_d, F0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
